alu_iter: RTL
=============

# alu_iter

Multi-cycle ALU responder inside the EXU. It accepts an operand pair and function code from the EXU operand-select logic over a valid/ready handshake and returns one registered result over a second valid/ready handshake. Non-shift operations complete in one cycle. Shifts are performed serially, one bit per cycle, which trades latency for area on the shift path.

## Interface
- `DATA_W`, default `` `ISA_WIDTH `` (32): operand and result width.
- `SHAMT_W`, default `$clog2(DATA_W)` (5): number of low bits of `in_b` used as the shift amount.
- `clk` input 1: the single clock.
- `rst` input 1: reset. Asynchronous, active-low.
- `in_valid` input 1: operand request is valid.
- `in_ready` output 1: block can accept a request.
- `in_a` input DATA_W: operand A.
- `in_b` input DATA_W: operand B, or the shift amount.
- `in_funct` input `` `ALU_FUNCT_WIDTH ``: function code, taken from the shared `` `ALU_FUNCT `` encodings in config.vh.
- `out_valid` output 1: result is valid.
- `out_ready` input 1: consumer takes the result.
- `out_result` output DATA_W: result. Registered, and held stable while `out_valid` is high.

## Operation
- **States.**
  - IDLE: `in_ready` = 1.
  - SHIFT: serial shift in progress; `in_ready` = 0.
  - DONE: `out_valid` = 1; `in_ready` = 0.
- **Accept.** A request is accepted when `in_valid && in_ready`. At acceptance the block latches `in_a`, `in_funct`, and `cnt = in_b[SHAMT_W-1:0]`.
- **Function results**, with a and b as the latched operands:
  - ADD: a+b, modulo 2^DATA_W. SUB: a−b, modulo 2^DATA_W.
  - XOR, OR, AND: bitwise.
  - EQ, NEQ, LESS (signed), GREATER_EQ (signed), LESS_U, GREATER_EQ_U: result is {DATA_W-1 zeros, flag}.
  - NO_FUNCT, and any unlisted code: result 0.
- **Non-shift path and zero shift.** For a non-shift function, or a shift with `cnt` = 0, the result is computed and registered in the accept cycle. Next state is DONE. A zero-amount shift yields `in_a` unchanged.
- **Shift path** (SHIFT_L_L, SHIFT_R_L, SHIFT_R_A) with `cnt` > 0: go to SHIFT.
  - Each SHIFT cycle shifts the working register by one bit and decrements `cnt`.
  - SHIFT_L_L fills with 0; SHIFT_R_L fills the MSB with 0; SHIFT_R_A replicates the MSB.
  - On the cycle where `cnt` reaches 0 after its decrement, next state is DONE.
  - Upper bits of `in_b` above SHAMT_W are ignored.
- **DONE.** The result is held until `out_valid && out_ready`, then the block returns to IDLE. A new request is never accepted in that same cycle, because `in_ready` is 0 in DONE.
- **Input changes.** `in_a`, `in_b` and `in_funct` may change freely after acceptance. Only the latched copies are used.
- **Reset.** Asserting `rst` low at any time, including mid-SHIFT or in DONE, immediately forces:
  - state IDLE
  - `out_valid` = 0, `out_result` = 0
  - `cnt` = 0
  - `in_ready` = 1 (valid once `rst` is deasserted)

  Any in-flight operation is discarded with no output.

## Timing
- **Reset values:** `in_ready` 1, `out_valid` 0, `out_result` 0.
- **Latency:** accept at cycle edge T.
  - Non-shift or zero shift: `out_valid` is high from T+1.
  - Shift of n > 0: `out_valid` is high from T+1+n. Maximum is T+DATA_W for n = DATA_W−1.
- **Throughput:** at most one request per 2 cycles for single-cycle operations, because IDLE→DONE→IDLE takes one cycle each when `out_ready` is held at 1.
- **Output handshake:**
  - `out_valid` is never deasserted without a handshake, except on reset.
  - `out_result` does not change while `out_valid` = 1.
- **Input handshake:** `in_ready` depends only on state. It has no combinational path from `in_valid` or `out_ready`.

## Test plan
- **ADD wrap.** Reset, then a=0xFFFF_FFFF, b=0x1, ADD, `out_ready`=1. Required: `out_valid` high exactly 1 cycle after accept, with `out_result`=0x0. Then `in_ready`=1 on the following cycle.
- **Compares.** a=0xFFFF_FFFE (−2), b=0x1:
  - LESS → 1
  - LESS_U → 0
  - GREATER_EQ_U → 1
  - EQ → 0
  - NO_FUNCT → 0
- **Shifts.**
  - a=0x8000_00F0, b=0x24 (shamt 4), SHIFT_R_A → 0xF800_000F, `out_valid` 5 cycles after accept.
  - Same operands with SHIFT_R_L → 0x0800_000F.
  - Same operands with SHIFT_L_L → 0x0000_0F00.
- **Extreme shift amounts.**
  - shamt 0: SHIFT_L_L with a=0x1234_5678, b=0x20 → 0x1234_5678 after 1 cycle.
  - shamt 31: SHIFT_L_L with a=0x1 → 0x8000_0000 after 32 cycles.
- **Backpressure.** Hold `out_ready`=0 for 10 cycles after DONE. Required:
  - `out_valid` and `out_result` remain stable.
  - `in_ready` stays 0 and a pending `in_valid` is not accepted.
  - `out_ready` then pulses for 1 cycle; IDLE follows, and the next request is accepted.
- **Mid-shift reset.** Start SHIFT_L_L with shamt 20, and drop `rst` asynchronously (between clock edges) at cycle 7. Required: `out_valid`=0, `out_result`=0 and `in_ready`=1 immediately. No stale result appears after reset is released.

Source files
------------

// File: rtl/alu_iter.sv
// alu_iter: multi-cycle ALU responder. Single-cycle arithmetic/logic/compare,
// serial one-bit-per-cycle shifts, valid/ready on both request and result.

package alu_iter_pkg;
  localparam int ISA_WIDTH   = 32;
  localparam int ALU_FUNCT_W = 4;

  localparam logic [ALU_FUNCT_W-1:0] FN_NO_FUNCT     = 4'd0;
  localparam logic [ALU_FUNCT_W-1:0] FN_ADD          = 4'd1;
  localparam logic [ALU_FUNCT_W-1:0] FN_SUB          = 4'd2;
  localparam logic [ALU_FUNCT_W-1:0] FN_XOR          = 4'd3;
  localparam logic [ALU_FUNCT_W-1:0] FN_OR           = 4'd4;
  localparam logic [ALU_FUNCT_W-1:0] FN_AND          = 4'd5;
  localparam logic [ALU_FUNCT_W-1:0] FN_SHIFT_L_L    = 4'd6;
  localparam logic [ALU_FUNCT_W-1:0] FN_SHIFT_R_L    = 4'd7;
  localparam logic [ALU_FUNCT_W-1:0] FN_SHIFT_R_A    = 4'd8;
  localparam logic [ALU_FUNCT_W-1:0] FN_EQ           = 4'd9;
  localparam logic [ALU_FUNCT_W-1:0] FN_NEQ          = 4'd10;
  localparam logic [ALU_FUNCT_W-1:0] FN_LESS         = 4'd11;
  localparam logic [ALU_FUNCT_W-1:0] FN_GREATER_EQ   = 4'd12;
  localparam logic [ALU_FUNCT_W-1:0] FN_LESS_U       = 4'd13;
  localparam logic [ALU_FUNCT_W-1:0] FN_GREATER_EQ_U = 4'd14;
endpackage

module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int DATA_W  = ISA_WIDTH,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_a,
  input  logic [DATA_W-1:0]      in_b,
  input  logic [ALU_FUNCT_W-1:0] in_funct,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_result
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                   state_r;
  logic                     ready_r;
  logic                     valid_r;
  logic [DATA_W-1:0]        result_r;   // doubles as the shift working register
  logic [SHAMT_W-1:0]       cnt_r;
  logic [ALU_FUNCT_W-1:0]   funct_r;
  logic [SHAMT_W-1:0]       shamt_s;
  logic                     start_shift_s;

  // Widen a compare flag into a full-width result.
  function automatic logic [DATA_W-1:0] to_flag(input logic flag);
    return {{(DATA_W-1){1'b0}}, flag};
  endfunction

  function automatic logic is_shift(input logic [ALU_FUNCT_W-1:0] f);
    return (f == FN_SHIFT_L_L) || (f == FN_SHIFT_R_L) || (f == FN_SHIFT_R_A);
  endfunction

  // Single-cycle result; shift codes only reach here with a zero amount.
  function automatic logic [DATA_W-1:0] alu_eval(input logic [DATA_W-1:0]      a,
                                                 input logic [DATA_W-1:0]      b,
                                                 input logic [ALU_FUNCT_W-1:0] f);
    logic [DATA_W-1:0] r;
    r = {DATA_W{1'b0}};
    case (f)
      FN_ADD:          r = a + b;
      FN_SUB:          r = a - b;
      FN_XOR:          r = a ^ b;
      FN_OR:           r = a | b;
      FN_AND:          r = a & b;
      FN_EQ:           r = to_flag(a == b);
      FN_NEQ:          r = to_flag(a != b);
      FN_LESS:         r = to_flag($signed(a) < $signed(b));
      FN_GREATER_EQ:   r = to_flag($signed(a) >= $signed(b));
      FN_LESS_U:       r = to_flag(a < b);
      FN_GREATER_EQ_U: r = to_flag(a >= b);
      FN_SHIFT_L_L,
      FN_SHIFT_R_L,
      FN_SHIFT_R_A:    r = a;
      default:         r = {DATA_W{1'b0}};
    endcase
    return r;
  endfunction

  // One serial shift step of the working register.
  function automatic logic [DATA_W-1:0] shift_one(input logic [DATA_W-1:0]      v,
                                                  input logic [ALU_FUNCT_W-1:0] f);
    logic [DATA_W-1:0] r;
    r = v;
    case (f)
      FN_SHIFT_L_L: r = {v[DATA_W-2:0], 1'b0};
      FN_SHIFT_R_L: r = {1'b0, v[DATA_W-1:1]};
      FN_SHIFT_R_A: r = {v[DATA_W-1], v[DATA_W-1:1]};
      default:      r = v;
    endcase
    return r;
  endfunction

  assign shamt_s       = in_b[SHAMT_W-1:0];
  assign start_shift_s = is_shift(in_funct) && (shamt_s != {SHAMT_W{1'b0}});

  // Control FSM with registered handshake outputs and result/working register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      ready_r  <= 1'b1;
      valid_r  <= 1'b0;
      result_r <= {DATA_W{1'b0}};
      cnt_r    <= {SHAMT_W{1'b0}};
      funct_r  <= FN_NO_FUNCT;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && ready_r) begin
            funct_r <= in_funct;
            cnt_r   <= shamt_s;
            ready_r <= 1'b0;
            if (start_shift_s) begin
              result_r <= in_a;
              state_r  <= ST_SHIFT;
            end else begin
              result_r <= alu_eval(in_a, in_b, in_funct);
              valid_r  <= 1'b1;
              state_r  <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          result_r <= shift_one(result_r, funct_r);
          cnt_r    <= cnt_r - SHAMT_W'(1);
          if (cnt_r == SHAMT_W'(1)) begin
            valid_r <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b1;
          valid_r <= 1'b0;
          cnt_r   <= {SHAMT_W{1'b0}};
        end
      endcase
    end
  end

  assign in_ready   = ready_r;
  assign out_valid  = valid_r;
  assign out_result = result_r;

endmodule
